// File: rtl/binary_addsub_pipe.sv
// ---------------------------------------------------------------------------
// binary_addsub_pipe
//   Pipelined WIDTH-bit adder/subtractor. The add is split into STAGES
//   carry-chained chunks of CHUNK bits, one chunk per pipeline stage, so each
//   stage contains only a CHUNK-bit ripple. Operands for the upper chunks are
//   skew-forwarded down the pipe alongside the completed lower sum chunks.
//   A global stall (out_valid & ~out_ready) freezes every stage.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  operand beat accepted this cycle (combinational from out_ready)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in (add) / borrow-in (sub)
//   sub        in   0: a+b+cin, 1: a-b-cin
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts result beat
//   sum        out  WIDTH-bit result modulo 2^WIDTH
//   cout       out  carry out of MSB (sub: 1 = no borrow)
//   ovf        out  two's-complement signed overflow
// ---------------------------------------------------------------------------
module binary_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Register k holds the state leaving stage k: operands (only the chunks
  // above k are still meaningful), the partial sum (chunks 0..k) and carry.
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0]            c_q, v_q;
  logic                         ovf_q;

  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_nx;
  logic [STAGES-1:0]            c_in, v_in, c_nx;
  logic [STAGES-1:0][CHUNK:0]   ck;
  logic                         ovf_nx;
  logic                         stall;

  always_comb begin
    a_in = '0;
    b_in = '0;
    s_in = '0;
    c_in = '0;
    v_in = '0;
    s_nx = '0;
    c_nx = '0;
    ck   = '0;

    // Subtract is a + ~b + ~cin: inverting the borrow-in turns the usual
    // "+1" of two's complement into "+1 - cin".
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub ? ~cin : cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      ck[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
            + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_in[k]};
      s_nx[k]                    = s_in[k];
      s_nx[k][k*CHUNK +: CHUNK]  = ck[k][CHUNK-1:0];
      c_nx[k]                    = ck[k][CHUNK];
    end

    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
    ovf_nx = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1]
           ^ s_nx[LAST][WIDTH-1] ^ c_nx[LAST];
  end

  assign stall     = v_q[LAST] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      a_q   <= a_in;
      b_q   <= b_in;
      s_q   <= s_nx;
      c_q   <= c_nx;
      v_q   <= v_in;
      ovf_q <= ovf_nx;
    end
  end

  // Already-consumed low operand chunks and the last stage's operand copy
  // are never read; synthesis trims them.
  logic unused_fwd;
  assign unused_fwd = ^{a_q, b_q};

endmodule

// File: tb/tb_binary_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_binary_addsub_pipe
//   Self-checking bench for binary_addsub_pipe (WIDTH=16, STAGES=4).
//   Expected results come from an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_binary_addsub_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks;
  int errors;

  binary_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    int          r;
    logic [31:0] ru;
    logic [15:0] rs;
    logic        co;
    logic        ov;
    if (!s) begin
      r  = int'(x) + int'(y) + int'(c);
      co = (r > 65535);
    end else begin
      r  = int'(x) - int'(y) - int'(c);
      co = (r >= 0);
    end
    ru = r;
    rs = ru[15:0];
    if (!s) ov = (x[15] == y[15]) && (rs[15] != x[15]);
    else    ov = (x[15] != y[15]) && (rs[15] != x[15]);
    return {ov, co, rs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if ({ovf, cout, sum} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs: got ovf=%b cout=%b sum=%h want 0/0/0000", ovf, cout, sum);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] ta [7] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0005, 16'h8000, 16'h0005};
    logic [15:0] tv [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0003};
    logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [17:0] te [7] = '{{2'b00, 16'h0100}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                            {2'b00, 16'h0001}, {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF},
                            {2'b01, 16'h0001}};
    logic early;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; a = ta[i]; b = tv[i]; cin = tc[i]; sub = ts[i];
      tick();
      in_valid = 1'b0;
      early = 1'b0;
      for (int c = 1; c < STAGES; c++) begin
        if (out_valid !== 1'b0) early = 1'b1;
        tick();
      end
      checks++;
      if (early) begin errors++; $display("FAIL directed_early[%0d]: out_valid 1 before cycle %0d, want 0", i, STAGES); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL directed_latency[%0d]: out_valid=%b want 1", i, out_valid); end
      checks++;
      if ({ovf, cout, sum} !== te[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                 i, ovf, cout, sum, te[i][17], te[i][16], te[i][15:0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [8];
    logic [15:0] bv [8];
    logic        bc [8];
    logic        bs [8];
    logic [17:0] held;
    logic [17:0] e;
    logic        dup;
    int sent = 0;
    int got  = 0;
    for (int i = 0; i < 8; i++) begin
      ba[i] = 16'($urandom); bv[i] = 16'($urandom);
      bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
    end
    held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (sent < 8) begin
        in_valid = 1'b1; a = ba[sent]; b = bv[sent]; cin = bc[sent]; sub = bs[sent];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_stall[%0d]: in_ready=%b out_valid=%b want 0/1", cyc, in_ready, out_valid);
        end
      end
      if (cyc == 5) held = {ovf, cout, sum};
      if (cyc == 6 || cyc == 7) begin
        checks++;
        if ({ovf, cout, sum} !== held) begin
          errors++; $display("FAIL b2b_hold[%0d]: got %h want %h", cyc, {ovf, cout, sum}, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = model(ba[got], bv[got], bc[got], bs[got]);
        checks++;
        if ({ovf, cout, sum} !== e) begin
          errors++; $display("FAIL b2b_result[%0d]: got %h want %h", got, {ovf, cout, sum}, e);
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      tick();
    end
    checks++;
    if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d results want 8", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    dup = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) dup = 1'b1;
      tick();
    end
    checks++;
    if (dup) begin errors++; $display("FAIL b2b_extra: out_valid=1 after all 8 results, want 0"); end
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] e;
    logic [17:0] prev_out;
    logic        prev_stall;
    int acc = 0;
    int got = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 40000 && got < 4000; cyc++) begin
      in_valid  = (acc < 4000) && ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h8000;
      if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== prev_out) begin
          errors++; $display("FAIL rand_hold[%0d]: out_valid=%b out=%h want 1/%h", cyc, out_valid, {ovf, cout, sum}, prev_out);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious[%0d]: result %h with none outstanding", cyc, {ovf, cout, sum});
        end else begin
          e = q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            errors++; $display("FAIL rand_result[%0d]: got %h want %h", got, {ovf, cout, sum}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(a, b, cin, sub));
        acc++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_out   = {ovf, cout, sum};
      tick();
    end
    checks++;
    if (got != 4000 || q.size() != 0) begin
      errors++; $display("FAIL rand_count: got %0d results, %0d pending, want 4000/0", got, q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_inflight();
    logic stale;
    logic early;
    logic [17:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'h1000 + 16'(i); b = 16'h0101; cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: out_valid=%b want 1 before reset", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {ovf, cout, sum} !== 18'h0) begin
      errors++; $display("FAIL rst_async: out_valid=%b out=%h want 0/0", out_valid, {ovf, cout, sum});
    end
    tick(); tick();
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      tick();
    end
    checks++;
    if (stale) begin errors++; $display("FAIL rst_stale: out_valid=1 after reset with nothing accepted, want 0"); end
    in_valid = 1'b1; a = 16'h1234; b = 16'h0F0F; cin = 1'b1; sub = 1'b1;
    e = model(16'h1234, 16'h0F0F, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    early = 1'b0;
    for (int c = 1; c < STAGES; c++) begin
      if (out_valid !== 1'b0) early = 1'b1;
      tick();
    end
    checks++;
    if (early || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_next_latency: early=%b out_valid=%b want 0/1", early, out_valid);
    end
    checks++;
    if ({ovf, cout, sum} !== e) begin
      errors++; $display("FAIL rst_next_result: got %h want %h", {ovf, cout, sum}, e);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
